// File: rtl/riscv_mmio_pkg.sv
// riscv_mmio_pkg
// Shared MMIO definitions for the Riscv151 memory-mapped I/O block.
// Holds the register offsets (addr[7:0]), STATUS bit positions, counter
// indices and a helper that assembles the STATUS word. The CPU top and the
// software headers take their offsets from here.
package riscv_mmio_pkg;

    // Register offsets within the MMIO region (only addr[7:0] is decoded)
    localparam logic [7:0] MMIO_STATUS  = 8'h00;
    localparam logic [7:0] MMIO_RX_DATA = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA = 8'h08;
    localparam logic [7:0] MMIO_CYCLE   = 8'h10;
    localparam logic [7:0] MMIO_INSTRET = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST = 8'h18;

    // STATUS bit positions
    localparam int STATUS_TX_NOT_FULL  = 0;
    localparam int STATUS_RX_NOT_EMPTY = 1;
    localparam int STATUS_RX_OCC_LSB   = 8;
    localparam int STATUS_TX_OCC_LSB   = 16;
    localparam int STATUS_OCC_WIDTH    = 8;

    // Counter bank indices
    localparam int CNT_CYCLE   = 0;
    localparam int CNT_INSTRET = 1;
    localparam int NUM_CNT     = 2;

    // Assemble the STATUS word; unlisted bits stay 0.
    function automatic logic [31:0] pack_status(
        input logic       tx_not_full,
        input logic       rx_not_empty,
        input logic [7:0] rx_occ,
        input logic [7:0] tx_occ
    );
        logic [31:0] w;
        w = '0;
        w[STATUS_TX_NOT_FULL]                            = tx_not_full;
        w[STATUS_RX_NOT_EMPTY]                           = rx_not_empty;
        w[STATUS_RX_OCC_LSB +: STATUS_OCC_WIDTH]         = rx_occ;
        w[STATUS_TX_OCC_LSB +: STATUS_OCC_WIDTH]         = tx_occ;
        return w;
    endfunction

endpackage

// File: rtl/riscv_mmio_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with combinational head output.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/count only)
//   push, din     write request and data; ignored while full
//   pop           read request; ignored while empty
//   dout          current head entry (combinational)
//   full, empty   status flags
//   count         occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // Full/empty gating applies to each side independently, so a pop on a
    // full FIFO still happens while the concurrent push is dropped.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count_reg == (AW + 1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    // Data storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mmio.sv
// riscv_mmio
// Memory-mapped I/O controller for the Riscv151 pipeline. Decodes the MMIO
// region from the execute-stage address, buffers UART RX/TX bytes in FIFOs
// and exposes cycle / retired-instruction counters. Read data is registered
// (one-cycle latency, like dmem and bios).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   addr, wdata, we, re            execute-stage bus (byte address, store data, strobes)
//   inst_retired                   one pulse per retired instruction
//   rdata                          load data, valid the cycle after re (0 otherwise)
//   uart_rx_data/valid/ready       byte stream from the UART receiver
//   uart_tx_data/valid/ready       byte stream to the UART transmitter
module riscv_mmio
    import riscv_mmio_pkg::*;
#(
    parameter int         RX_DEPTH    = 8,
    parameter int         TX_DEPTH    = 8,
    parameter int         CNT_WIDTH   = 32,
    parameter logic [3:0] MMIO_NIBBLE = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retired,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]  off;
    logic        sel;
    logic        wr_en;
    logic        rd_en;
    logic        cnt_clr;
    logic        rx_pop;
    logic        tx_push;

    logic [7:0]       rx_dout;
    logic             rx_full;
    logic             rx_empty;
    logic [RX_CW-1:0] rx_count;
    logic [7:0]       tx_dout;
    logic             tx_full;
    logic             tx_empty;
    logic [TX_CW-1:0] tx_count;

    logic [CNT_WIDTH-1:0] cnt_reg [NUM_CNT];
    logic [NUM_CNT-1:0]   cnt_inc;

    logic [31:0] status_word;
    logic [31:0] rd_mux;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;

    logic unused_bits;
    assign unused_bits = ^{addr[27:8], wdata[31:8]};

    // Address decode. A simultaneous we/re is treated as a write only.
    assign sel     = (addr[31:28] == MMIO_NIBBLE);
    assign off     = addr[7:0];
    assign wr_en   = sel & we;
    assign rd_en   = sel & re & ~we;
    assign cnt_clr = wr_en & (off == MMIO_CNT_RST);
    assign rx_pop  = rd_en & (off == MMIO_RX_DATA);
    assign tx_push = wr_en & (off == MMIO_TX_DATA);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid),
        .pop   (rx_pop),
        .din   (uart_rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (uart_tx_ready),
        .din   (wdata[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign uart_rx_ready = ~rx_full;
    assign uart_tx_valid = ~tx_empty;
    // Mask the head while empty so the un-reset storage never leaks out.
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_dout;

    // Counter bank: CYCLE always counts, INSTRET on retire pulses.
    // A CNT_RST write overrides any same-cycle increment.
    assign cnt_inc[CNT_CYCLE]   = 1'b1;
    assign cnt_inc[CNT_INSTRET] = inst_retired;

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi]) begin
                cnt_reg[gi] <= cnt_reg[gi] + CNT_WIDTH'(1);
            end
        end
    end

    // STATUS sees pre-edge occupancy because it samples the FIFO counts
    // combinationally in the read cycle.
    assign status_word = pack_status(~tx_full, ~rx_empty,
                                     8'(rx_count), 8'(tx_count));

    always_comb begin
        rd_mux = '0;
        case (off)
            MMIO_STATUS:  rd_mux = status_word;
            MMIO_RX_DATA: rd_mux = rx_empty ? 32'h0 : {24'h0, rx_dout};
            MMIO_CYCLE:   rd_mux = 32'(cnt_reg[CNT_CYCLE]);
            MMIO_INSTRET: rd_mux = 32'(cnt_reg[CNT_INSTRET]);
            default:      rd_mux = '0;
        endcase
        rdata_next = rd_en ? rd_mux : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= rdata_next;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_riscv_mmio.sv
// tb_riscv_mmio
// Scoreboard bench for riscv_mmio. Two instances share all inputs: one with a
// 32-bit counter width and one with a 4-bit counter width (wrap checks).
// A reference model (byte queues + integer counters) runs on each rising
// edge and pushes the expected next rdata into a queue; a monitor on the
// falling edge pops and compares, and checks the UART handshake outputs.
module tb_riscv_mmio;

    localparam int RXD = 8;
    localparam int TXD = 8;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retired;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_tx_ready;

    logic [31:0] rdata;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic [31:0] rdata4;
    logic        uart_rx_ready4;
    logic [7:0]  uart_tx_data4;
    logic        uart_tx_valid4;

    riscv_mmio #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_WIDTH(32), .MMIO_NIBBLE(4'h8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retired(inst_retired), .rdata(rdata),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
    );

    riscv_mmio #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_WIDTH(4), .MMIO_NIBBLE(4'h8)) dut4 (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retired(inst_retired), .rdata(rdata4),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready4),
        .uart_tx_data(uart_tx_data4), .uart_tx_valid(uart_tx_valid4), .uart_tx_ready(uart_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] e32;
        logic [31:0] e4;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    longint      cyc;
    longint      ins;
    bit          model_live = 0;

    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) begin
        exp_t       e;
        int         rxn;
        int         txn;
        bit         s;
        logic [7:0] o;
        e.e32 = 32'h0;
        e.e4  = 32'h0;
        if (rst) begin
            rxq.delete();
            txq.delete();
            cyc = 0;
            ins = 0;
        end else begin
            rxn = rxq.size();
            txn = txq.size();
            s   = (addr[31:28] == 4'h8);
            o   = addr[7:0];
            if (re && !we && s) begin
                case (o)
                    8'h00: begin
                        e.e32 = (txn < TXD ? 32'h1 : 32'h0)
                              | (rxn != 0 ? 32'h2 : 32'h0)
                              | (32'(rxn) << 8) | (32'(txn) << 16);
                        e.e4 = e.e32;
                    end
                    8'h04: begin
                        e.e32 = (rxn != 0) ? {24'h0, rxq[0]} : 32'h0;
                        e.e4  = e.e32;
                    end
                    8'h10: begin
                        e.e32 = 32'(cyc % 64'h1_0000_0000);
                        e.e4  = 32'(cyc % 16);
                    end
                    8'h14: begin
                        e.e32 = 32'(ins % 64'h1_0000_0000);
                        e.e4  = 32'(ins % 16);
                    end
                    default: ;
                endcase
                if (o == 8'h04 && rxn != 0) void'(rxq.pop_front());
            end
            if (uart_rx_valid && rxn < RXD) rxq.push_back(uart_rx_data);
            if (uart_tx_ready && txn != 0) void'(txq.pop_front());
            if (we && s && o == 8'h08 && txn < TXD) txq.push_back(wdata[7:0]);
            if (we && s && o == 8'h18) begin
                cyc = 0;
                ins = 0;
            end else begin
                cyc = cyc + 1;
                if (inst_retired) ins = ins + 1;
            end
        end
        expq.push_back(e);
        model_live = 1;
    end

    // ---------------- monitor ----------------
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("rdata", rdata, e.e32);
            check("rdata_cnt4", rdata4, e.e4);
        end
        if (model_live) begin
            check("tx_valid", {31'h0, uart_tx_valid}, {31'h0, txq.size() != 0});
            check("tx_data", {24'h0, uart_tx_data}, {24'h0, (txq.size() != 0) ? txq[0] : 8'h00});
            check("rx_ready", {31'h0, uart_rx_ready}, {31'h0, rxq.size() < RXD});
            check("tx_valid4", {31'h0, uart_tx_valid4}, {31'h0, txq.size() != 0});
            check("rx_ready4", {31'h0, uart_rx_ready4}, {31'h0, rxq.size() < RXD});
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] BASE = 32'h8000_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        we = w;
        re = r;
        addr = a;
        wdata = d;
        step();
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic rd(input logic [7:0] o);
        bus(1'b0, 1'b1, BASE | 32'(o), 32'h0);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        bus(1'b1, 1'b0, BASE | 32'(o), d);
    endtask

    logic [7:0] offs [8];

    initial begin
        offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        inst_retired = 1'b0; uart_rx_data = 8'h0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset STATUS, then CYCLE a few cycles after release
        rd(8'h00);
        idle(3);
        rd(8'h10);

        // Two RX bytes, three RX reads, STATUS
        uart_rx_valid = 1'b1; uart_rx_data = 8'h41; step();
        uart_rx_data = 8'h42; step();
        uart_rx_valid = 1'b0;
        rd(8'h04); rd(8'h04); rd(8'h04); rd(8'h00);

        // Overfill TX with the transmitter stalled, then drain
        for (int i = 1; i <= 9; i++) wr(8'h08, 32'(i));
        rd(8'h00);
        uart_tx_ready = 1'b1;
        idle(12);
        uart_tx_ready = 1'b0;

        // Fill RX past depth, pop once while full, then push+pop together
        uart_rx_valid = 1'b1;
        for (int i = 0; i < RXD + 2; i++) begin
            uart_rx_data = 8'($urandom);
            step();
        end
        uart_rx_valid = 1'b0;
        rd(8'h04);
        step();
        rd(8'h00);
        uart_rx_valid = 1'b1; uart_rx_data = 8'hA5;
        rd(8'h04);
        uart_rx_valid = 1'b0;
        rd(8'h00);
        for (int i = 0; i < RXD; i++) rd(8'h04);

        // INSTRET pulses, clear coinciding with a pulse
        for (int i = 0; i < 3; i++) begin
            inst_retired = 1'b1; step();
            inst_retired = 1'b0; step();
        end
        rd(8'h14);
        inst_retired = 1'b1;
        wr(8'h18, 32'h0);
        inst_retired = 1'b0;
        rd(8'h14);
        rd(8'h10);

        // Let the 4-bit counter wrap
        idle(14);
        rd(8'h10);
        rd(8'h10);

        // Simultaneous we/re, unmapped offset, foreign region
        bus(1'b1, 1'b1, BASE | 32'h10, 32'h0);
        rd(8'h0C);
        bus(1'b0, 1'b1, 32'h3000_0010, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 249) == 0);
            addr          = ($urandom_range(0, 7) == 0) ? {4'h3, 20'($urandom), offs[$urandom_range(0, 7)]}
                                                        : {4'h8, 20'($urandom), offs[$urandom_range(0, 7)]};
            we            = ($urandom_range(0, 3) == 0);
            re            = ($urandom_range(0, 2) == 0);
            wdata         = $urandom;
            uart_rx_valid = ($urandom_range(0, 1) == 1);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(0, 2) == 0);
            inst_retired  = ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 1'b0; we = 1'b0; re = 1'b0; uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0; inst_retired = 1'b0;
        idle(3);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mmio.md
# riscv_mmio

Memory-mapped I/O controller for the Riscv151 pipeline. It decodes the MMIO region (address nibble `4'h8`) from the execute-stage data address and buffers UART traffic in parametrised RX/TX FIFOs. It also provides cycle and retired-instruction counters to software. Read data is registered, so it has the same one-cycle latency as dmem and bios and joins the memory-stage load mux alongside them.

## Interface
Parameters:
- `RX_DEPTH`, 8: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 32: counter width, 1..32; reads are zero-extended to 32 bits.
- `MMIO_NIBBLE`, 4'h8: value of `addr[31:28]` that selects this block.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `addr`  in  32  execute-stage byte address (ALU result)
- `wdata`  in  32  store data
- `we`  in  1  store strobe
- `re`  in  1  load strobe
- `inst_retired`  in  1  one pulse per retired instruction
- `rdata`  out  32  load data, valid the cycle after `re`
- `uart_rx_data`  in  8  received byte
- `uart_rx_valid`  in  1  received byte present
- `uart_rx_ready`  out  1  `!rx_full`
- `uart_tx_data`  out  8  head of TX FIFO
- `uart_tx_valid`  out  1  `!tx_empty`
- `uart_tx_ready`  in  1  UART accepts byte

## Operation
- Select: `sel = (addr[31:28] == MMIO_NIBBLE)`. Only `addr[7:0]` is decoded. Unmapped offsets read 0 and ignore writes.
- Register map (read/write):
  - 0x00 STATUS (R): bit0 = TX not full; bit1 = RX not empty; bits[15:8] = RX occupancy; bits[23:16] = TX occupancy; other bits 0.
  - 0x04 RX_DATA (R): `{24'b0, rx_head}`. The read pops RX.
  - 0x08 TX_DATA (W): pushes `wdata[7:0]` into TX.
  - 0x10 CYCLE (R): cycle counter.
  - 0x14 INSTRET (R): instruction counter.
  - 0x18 CNT_RST (W): any write clears both counters.
- RX pop fires in the `re` cycle. A pop on an empty RX is suppressed, and the read returns 0.
- TX push with TX full: the byte is dropped silently, with no error flag.
- RX push on `uart_rx_valid && uart_rx_ready`; TX pop on `uart_tx_valid && uart_tx_ready`.
- Simultaneous push and pop on the same FIFO: both take effect and occupancy is unchanged. The full/empty gating above applies independently to each operation.
- CYCLE increments every cycle out of reset. INSTRET increments when `inst_retired` is high. Both wrap modulo 2^CNT_WIDTH.
- CNT_RST write in the same cycle as an increment: the clear wins, and the counter reads 0 the next cycle.
- `we && re` in the same cycle: treated as a write only; `rdata` is 0 next cycle.

## Timing
- Reset values:
  - `rdata` = 0.
  - Both FIFOs empty, so `uart_tx_valid` = 0 and `uart_rx_ready` = 1.
  - Both counters = 0.
  - `uart_tx_data` = 0.
- Read latency is 1 cycle. `rdata` captures the selected value at the `re` edge; otherwise `rdata` = 0 the following cycle.
- STATUS reflects the state before the same-cycle edge. A STATUS read returns pre-edge occupancy.
- A write takes effect at the edge of the `we` cycle. A TX byte pushed into an empty FIFO shows `uart_tx_valid` = 1 the next cycle.
- FIFO data memories are not reset. Pointers and counts are reset.
- `rst` mid-transfer: on the next edge, FIFOs empty and pending bytes are lost.

## Structure
- Shared package `riscv_mmio_pkg` holds the offset constants `MMIO_STATUS`, `MMIO_RX_DATA`, `MMIO_TX_DATA`, `MMIO_CYCLE`, `MMIO_INSTRET`, `MMIO_CNT_RST`, and the STATUS bit positions. The CPU top and software headers reuse them.
- Sub-module `sync_fifo` with parameters `WIDTH` and `DEPTH`. Ports: `push`, `pop`, `din`, `dout` (head, combinational), `full`, `empty`, `count[$clog2(DEPTH):0]`. It is instantiated twice, for RX and TX.

## Test plan
- Reset, then read STATUS: `rdata` = 0x0000_0001. CYCLE read 5 cycles after reset release returns 4 or 5, exactly matching a reference counter.
- Drive `uart_rx_data` 0x41, 0x42, then read RX_DATA twice: returns 0x41, then 0x42. A third read returns 0, and STATUS bit1 = 0.
- Write 9 bytes to TX_DATA with `uart_tx_ready` = 0 and TX_DEPTH = 8: STATUS bits[23:16] = 8, bit0 = 0. Raising ready emits bytes 1–8 in order, and the 9th is absent.
- Fill RX to RX_DEPTH: `uart_rx_ready` = 0. One RX_DATA read raises it the next cycle. Simultaneous RX push and pop holds occupancy.
- Pulse `inst_retired` 3 times, then write CNT_RST in the same cycle as a 4th pulse: INSTRET reads 0, and CYCLE restarts from 0.
- With CNT_WIDTH = 4, let CYCLE run 16 cycles: it wraps to 0, and reads are zero-extended.
